sdram_burst_reader: RTL and testbench

Read initiator for the lab SDRAM word-memory model. It accepts a burst request (byte base address, word count) from a client and issues one single-word read at a time on the memory read port. Each returned word is captured into a small internal FIFO and streamed to the consumer over a valid/ready interface, with the final word tagged. It sits between processing logic, such as a DMA or accelerator front end, and the SDRAM read port.

---
 rtl/sdram_pkg.sv | 18 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/sdram_burst_reader.sv | 149 ++++++++++++++
 tb/tb_sdram_burst_reader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read initiator: word geometry, default widths
// and the reader state encoding.
package sdram_pkg;

  localparam int WORD_BYTES     = 4;
  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } reader_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO built from registers; the head word is
// presented combinationally so the consumer sees it in the cycle after the push.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]            wr_ptr_reg;
  logic [PTR_W-1:0]            rd_ptr_reg;
  logic [PTR_W:0]              count_reg;
  logic [DEPTH-1:0][WIDTH-1:0] entries;
  logic                        push_en;
  logic                        pop_en;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign count   = count_reg;
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (push_en && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= din;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  assign dout = entries[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sdram_burst_reader.sv
// Burst read initiator: turns a (base, length) request into single-word reads,
// one outstanding at a time, and streams the words out with the last one tagged.
module sdram_burst_reader
  import sdram_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int LEN_W      = DEFAULT_LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  reader_state_t     state_reg;
  reader_state_t     state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_next;
  logic [LEN_W-1:0]  rem_reg;
  logic [LEN_W-1:0]  rem_next;

  logic              accept;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W:0]   fifo_dout;
  logic              last_word;

  assign accept    = (state_reg == IDLE) && req_valid;
  assign fifo_push = (state_reg == WAIT) && mem_data_valid;
  assign fifo_pop  = out_valid && out_ready;
  assign last_word = (rem_reg == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = (req_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (!fifo_full) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_data_valid) begin
          state_next = last_word ? DRAIN : ISSUE;
        end
      end
      // The last pop can happen in this very cycle, so leave one cycle early.
      DRAIN: begin
        if (fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_read  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ISSUE:   mem_read = !fifo_full;
      DONE:    done     = 1'b1;
      default: ;
    endcase
  end

  // Masking rather than slicing keeps every address bit in the expression.
  always_comb begin
    addr_next = addr_reg;
    rem_next  = rem_reg;
    if (accept) begin
      addr_next = req_addr & ~ADDR_W'(WORD_BYTES - 1);
      rem_next  = req_len;
    end else if (fifo_push) begin
      addr_next = addr_reg + ADDR_W'(WORD_BYTES);
      rem_next  = rem_reg - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
      rem_reg  <= '0;
    end else begin
      addr_reg <= addr_next;
      rem_reg  <= rem_next;
    end
  end

  assign mem_addr = addr_reg;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({last_word, mem_data}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_dout[DATA_W-1:0];
  assign out_last  = fifo_dout[DATA_W];

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Directed bench for sdram_burst_reader against a registered word-memory model
// preloaded with mem[i] = i + 1 and mem_data_valid tied high.
module tb_sdram_burst_reader;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic        mem_data_valid;
  logic [31:0] mem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sdram_mem [256];
  logic [32:0] pop_q [$];
  logic [32:0] exp_q [$];
  logic [31:0] addr_q [$];
  int          strobe_cnt = 0;
  int          done_cnt   = 0;

  sdram_burst_reader dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .mem_read       (mem_read),
    .mem_addr       (mem_addr),
    .mem_data_valid (mem_data_valid),
    .mem_data       (mem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) sdram_mem[i] = 32'(i + 1);
  end

  assign mem_data_valid = 1'b1;
  always @(posedge clk) begin
    if (mem_read) mem_data <= sdram_mem[mem_addr[9:2]];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) pop_q.push_back({out_last, out_data});
      if (mem_read) begin
        strobe_cnt++;
        addr_q.push_back(mem_addr);
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] w(input int data, input bit last);
    return {last, 32'(data)};
  endfunction

  task automatic clear_mon();
    pop_q.delete();
    addr_q.delete();
    strobe_cnt = 0;
    done_cnt   = 0;
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, 64'(pop_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < pop_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), 64'(pop_q[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic start_req(input logic [31:0] addr, input logic [15:0] len);
    logic acc;
    int   n;
    req_addr  = addr;
    req_len   = len;
    req_valid = 1'b1;
    n = 0;
    do begin
      acc = req_ready;
      tick();
      n++;
    end while (!acc && n < 100);
    req_valid = 1'b0;
    check("accept", 64'(acc), 64'(1));
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'(1));
  endtask

  initial begin
    int n;
    logic acc;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_mem_read", 64'(mem_read), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));

    // Scenario 1: aligned burst of 4, no backpressure, latency and throughput
    clear_mon();
    out_ready = 1'b1;
    req_addr  = 32'h0;
    req_len   = 16'd4;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("s1_e0_mem_read", 64'(mem_read), 64'(1));
    check("s1_e0_mem_addr", 64'(mem_addr), 64'(0));
    check("s1_e0_busy", 64'(busy), 64'(1));
    tick();
    check("s1_e1_mem_read", 64'(mem_read), 64'(0));
    check("s1_e1_out_valid", 64'(out_valid), 64'(0));
    tick();
    check("s1_e2_out_valid", 64'(out_valid), 64'(1));
    check("s1_e2_out_data", 64'(out_data), 64'(1));
    wait_done("s1", n);
    check("s1_done_latency", 64'(n), 64'(7));
    tick();
    check("s1_busy_after", 64'(busy), 64'(0));
    check("s1_done_after", 64'(done), 64'(0));
    exp_q = '{w(1, 0), w(2, 0), w(3, 0), w(4, 1)};
    check_stream("s1_stream");
    check("s1_strobes", 64'(addr_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      check($sformatf("s1_addr[%0d]", i), 64'(addr_q[i]), 64'(i * 4));
    check("s1_done_count", 64'(done_cnt), 64'(1));
    $display("txn s1 addr=0x0 len=4 words=%0d done=%0d", pop_q.size(), done_cnt);

    // Scenario 2: backpressure fills the FIFO and stalls issue
    clear_mon();
    out_ready = 1'b0;
    start_req(32'h100, 16'd6);
    repeat (20) tick();
    check("s2_strobes_stalled", 64'(strobe_cnt), 64'(4));
    check("s2_mem_read_stalled", 64'(mem_read), 64'(0));
    check("s2_busy_stalled", 64'(busy), 64'(1));
    check("s2_mem_addr_stalled", 64'(mem_addr), 64'(32'h110));
    check("s2_head", 64'(out_data), 64'(65));
    out_ready = 1'b1;
    wait_done("s2", n);
    tick();
    exp_q = '{w(65, 0), w(66, 0), w(67, 0), w(68, 0), w(69, 0), w(70, 1)};
    check_stream("s2_stream");
    check("s2_strobes_total", 64'(strobe_cnt), 64'(6));
    check("s2_done_count", 64'(done_cnt), 64'(1));
    $display("txn s2 addr=0x100 len=6 words=%0d done=%0d", pop_q.size(), done_cnt);

    // Scenario 3: misaligned base address
    clear_mon();
    start_req(32'h13, 16'd1);
    wait_done("s3", n);
    tick();
    check("s3_addr", 64'(addr_q.size() > 0 ? addr_q[0] : 32'hFFFF_FFFF), 64'(32'h10));
    exp_q = '{w(5, 1)};
    check_stream("s3_stream");
    check("s3_done_count", 64'(done_cnt), 64'(1));
    $display("txn s3 addr=0x13 len=1 words=%0d done=%0d", pop_q.size(), done_cnt);

    // Scenario 4: zero-length request
    clear_mon();
    start_req(32'h40, 16'd0);
    check("s4_done_pulse", 64'(done), 64'(1));
    check("s4_req_ready_busy", 64'(req_ready), 64'(0));
    tick();
    check("s4_done_end", 64'(done), 64'(0));
    check("s4_req_ready_back", 64'(req_ready), 64'(1));
    check("s4_no_strobe", 64'(strobe_cnt), 64'(0));
    check("s4_done_count", 64'(done_cnt), 64'(1));
    $display("txn s4 addr=0x40 len=0 strobes=%0d done=%0d", strobe_cnt, done_cnt);

    // Scenario 5: reset after the third pop aborts the burst
    clear_mon();
    start_req(32'h0, 16'd8);
    n = 0;
    while (pop_q.size() < 3 && n < 100) begin
      tick();
      n++;
    end
    check("s5_three_pops", 64'(pop_q.size()), 64'(3));
    rst = 1'b1;
    tick();
    check("s5_out_valid", 64'(out_valid), 64'(0));
    check("s5_mem_read", 64'(mem_read), 64'(0));
    check("s5_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    repeat (10) tick();
    check("s5_no_done", 64'(done_cnt), 64'(0));
    check("s5_still_empty", 64'(out_valid), 64'(0));
    $display("txn s5 addr=0x0 len=8 reset_after=%0d done=%0d", pop_q.size(), done_cnt);
    clear_mon();
    start_req(32'h20, 16'd2);
    wait_done("s5b", n);
    tick();
    exp_q = '{w(9, 0), w(10, 1)};
    check_stream("s5b_stream");
    $display("txn s5b addr=0x20 len=2 words=%0d done=%0d", pop_q.size(), done_cnt);

    // Scenario 6: back-to-back requests with req_valid held
    clear_mon();
    start_req(32'h0, 16'd2);
    req_addr  = 32'h40;
    req_len   = 16'd2;
    req_valid = 1'b1;
    n = 0;
    do begin
      acc = req_ready;
      if (acc) check("s6_second_after_done", 64'(done_cnt), 64'(1));
      tick();
      n++;
    end while (!acc && n < 100);
    req_valid = 1'b0;
    check("s6_second_accept", 64'(acc), 64'(1));
    wait_done("s6", n);
    tick();
    exp_q = '{w(1, 0), w(2, 1), w(17, 0), w(18, 1)};
    check_stream("s6_stream");
    check("s6_done_count", 64'(done_cnt), 64'(2));
    $display("txn s6 addr=0x0,0x40 len=2,2 words=%0d done=%0d", pop_q.size(), done_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
